dmem_arbiter: RTL and testbench

//  Shares the single banked data memory port (15-bit byte address, 32-bit data, memType-coded

---
 rtl/dmem_pkg.sv | 16 +
 rtl/dmem_align_chk.sv | 21 ++
 rtl/dmem_arbiter.sv | 165 ++++++++++++++++
 tb/tb_dmem_arbiter.sv | 337 +++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/dmem_pkg.sv
// Shared data-memory definitions: memType access codes and arbiter state encoding.
package dmem_pkg;

    localparam logic [2:0] MT_B  = 3'b000;
    localparam logic [2:0] MT_H  = 3'b001;
    localparam logic [2:0] MT_W  = 3'b010;
    localparam logic [2:0] MT_BU = 3'b100;
    localparam logic [2:0] MT_HU = 3'b101;

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        RD_RSP = 2'd1,
        BOOT   = 2'd2
    } arb_state_t;

endpackage

// File: rtl/dmem_align_chk.sv
// Combinational alignment check of a memType access against its byte offset.
// Unknown memType codes are reported as misaligned so they never reach the banks.
module dmem_align_chk
    import dmem_pkg::*;
(
    input  logic [1:0] addr_lo,
    input  logic [2:0] acc_type,
    output logic       misalign
);

    always_comb begin
        misalign = 1'b1;
        case (acc_type)
            MT_B, MT_BU: misalign = 1'b0;
            MT_H, MT_HU: misalign = addr_lo[0];
            MT_W:        misalign = (addr_lo != 2'b00);
            default:     misalign = 1'b1;
        endcase
    end

endmodule

// File: rtl/dmem_arbiter.sv
// Arbitrates the data memory port between CPU load/store and boot word writer.
// Stores and boot writes take 0 wait cycles; loads stall the CPU one cycle; boot ownership stalls the CPU.
module dmem_arbiter
    import dmem_pkg::*;
#(
    parameter int ADDR_W = 15,
    parameter int DATA_W = 32,
    parameter int CNT_W  = 13
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              cpu_req,
    input  logic              cpu_we,
    input  logic [ADDR_W-1:0] cpu_addr,
    input  logic [2:0]        cpu_type,
    input  logic [DATA_W-1:0] cpu_wdata,
    output logic              cpu_stall,
    output logic              cpu_rvalid,
    output logic [DATA_W-1:0] cpu_rdata,
    output logic              cpu_misalign,
    input  logic              boot_mode,
    input  logic              boot_valid,
    input  logic [ADDR_W-1:0] boot_addr,
    input  logic [DATA_W-1:0] boot_wdata,
    output logic              boot_ready,
    output logic [CNT_W-1:0]  boot_count,
    output logic [ADDR_W-1:0] mem_addr,
    output logic              mem_write,
    output logic              mem_read,
    output logic [2:0]        mem_type,
    output logic [DATA_W-1:0] mem_data_in,
    input  logic [DATA_W-1:0] mem_data_out
);

    arb_state_t        state_q, state_d;
    logic [ADDR_W-1:0] rd_addr_q, rd_addr_d;
    logic [2:0]        rd_type_q, rd_type_d;
    logic [DATA_W-1:0] rdata_q, rdata_d;
    logic [CNT_W-1:0]  boot_count_q, boot_count_d;
    logic              cpu_misaligned;
    logic              boot_addr_unused;

    // Boot words are always word-aligned; the low address bits carry no information.
    assign boot_addr_unused = ^boot_addr[1:0];

    dmem_align_chk u_align_chk (
        .addr_lo  (cpu_addr[1:0]),
        .acc_type (cpu_type),
        .misalign (cpu_misaligned)
    );

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q      <= IDLE;
            rd_addr_q    <= '0;
            rd_type_q    <= MT_W;
            rdata_q      <= '0;
            boot_count_q <= '0;
        end else begin
            state_q      <= state_d;
            rd_addr_q    <= rd_addr_d;
            rd_type_q    <= rd_type_d;
            rdata_q      <= rdata_d;
            boot_count_q <= boot_count_d;
        end
    end

    always_comb begin
        state_d      = state_q;
        rd_addr_d    = rd_addr_q;
        rd_type_d    = rd_type_q;
        rdata_d      = rdata_q;
        boot_count_d = boot_count_q;
        case (state_q)
            IDLE: begin
                if (boot_mode) begin
                    state_d      = BOOT;
                    boot_count_d = '0;
                end else if (cpu_req && !cpu_we && !cpu_misaligned) begin
                    state_d   = RD_RSP;
                    rd_addr_d = cpu_addr;
                    rd_type_d = cpu_type;
                end
            end
            RD_RSP: begin
                // The read always finishes; a boot request raised meanwhile is honoured next.
                rdata_d = mem_data_out;
                if (boot_mode) begin
                    state_d      = BOOT;
                    boot_count_d = '0;
                end else begin
                    state_d = IDLE;
                end
            end
            BOOT: begin
                if (boot_valid) begin
                    boot_count_d = boot_count_q + CNT_W'(1);
                end
                if (!boot_mode) begin
                    state_d = IDLE;
                end
            end
            default: state_d = IDLE;
        endcase
    end

    always_comb begin
        cpu_stall    = 1'b0;
        cpu_rvalid   = 1'b0;
        cpu_misalign = 1'b0;
        cpu_rdata    = rdata_q;
        boot_ready   = 1'b0;
        mem_addr     = '0;
        mem_write    = 1'b0;
        mem_read     = 1'b0;
        mem_type     = MT_W;
        mem_data_in  = '0;
        if (rst) begin
            cpu_rdata = '0;
        end else begin
            case (state_q)
                IDLE: begin
                    if (boot_mode) begin
                        cpu_stall = cpu_req;
                    end else if (cpu_req) begin
                        if (cpu_misaligned) begin
                            cpu_misalign = 1'b1;
                        end else if (cpu_we) begin
                            mem_write   = 1'b1;
                            mem_addr    = cpu_addr;
                            mem_type    = cpu_type;
                            mem_data_in = cpu_wdata;
                        end else begin
                            mem_read  = 1'b1;
                            mem_addr  = cpu_addr;
                            mem_type  = cpu_type;
                            cpu_stall = 1'b1;
                        end
                    end
                end
                RD_RSP: begin
                    // Memory decodes the returned word using addr/type of the data cycle.
                    mem_read   = 1'b1;
                    mem_addr   = rd_addr_q;
                    mem_type   = rd_type_q;
                    cpu_rvalid = 1'b1;
                    cpu_rdata  = mem_data_out;
                end
                BOOT: begin
                    boot_ready = 1'b1;
                    cpu_stall  = cpu_req;
                    if (boot_valid) begin
                        mem_write   = 1'b1;
                        mem_addr    = {boot_addr[ADDR_W-1:2], 2'b00};
                        mem_data_in = boot_wdata;
                    end
                end
                default: ;
            endcase
        end
    end

    assign boot_count = boot_count_q;

endmodule

// File: tb/tb_dmem_arbiter.sv
// Directed bench for dmem_arbiter with a byte-level reference model and a word-level memory.
module tb_dmem_arbiter;
    import dmem_pkg::*;

    logic        clk = 1'b0;
    logic        rst;
    logic        cpu_req, cpu_we;
    logic [14:0] cpu_addr;
    logic [2:0]  cpu_type;
    logic [31:0] cpu_wdata;
    logic        cpu_stall, cpu_rvalid, cpu_misalign;
    logic [31:0] cpu_rdata;
    logic        boot_mode, boot_valid;
    logic [14:0] boot_addr;
    logic [31:0] boot_wdata;
    logic        boot_ready;
    logic [12:0] boot_count;
    logic [14:0] mem_addr;
    logic        mem_write, mem_read;
    logic [2:0]  mem_type;
    logic [31:0] mem_data_in, mem_data_out;

    int n_vec = 0;
    int n_err = 0;

    always #5 clk = ~clk;

    dmem_arbiter dut (
        .clk(clk), .rst(rst),
        .cpu_req(cpu_req), .cpu_we(cpu_we), .cpu_addr(cpu_addr), .cpu_type(cpu_type),
        .cpu_wdata(cpu_wdata), .cpu_stall(cpu_stall), .cpu_rvalid(cpu_rvalid),
        .cpu_rdata(cpu_rdata), .cpu_misalign(cpu_misalign),
        .boot_mode(boot_mode), .boot_valid(boot_valid), .boot_addr(boot_addr),
        .boot_wdata(boot_wdata), .boot_ready(boot_ready), .boot_count(boot_count),
        .mem_addr(mem_addr), .mem_write(mem_write), .mem_read(mem_read),
        .mem_type(mem_type), .mem_data_in(mem_data_in), .mem_data_out(mem_data_out)
    );

    // Word-organised memory standing in for the banked instance: 1-cycle synchronous read,
    // result decoded with the address/type presented in the data cycle.
    logic [31:0] bmem [0:8191];
    logic [31:0] raw_q;

    always @(posedge clk) begin
        int lane;
        lane = 8 * int'(mem_addr[1:0]);
        if (mem_write) begin
            case (mem_type[1:0])
                2'b00:   bmem[mem_addr[14:2]][lane +: 8]  <= mem_data_in[7:0];
                2'b01:   bmem[mem_addr[14:2]][lane +: 16] <= mem_data_in[15:0];
                default: bmem[mem_addr[14:2]]             <= mem_data_in;
            endcase
        end
        if (mem_read) raw_q <= bmem[mem_addr[14:2]];
    end

    always_comb begin
        logic [31:0] sh;
        sh = raw_q >> (8 * int'(mem_addr[1:0]));
        case (mem_type)
            MT_B:    mem_data_out = {{24{sh[7]}}, sh[7:0]};
            MT_BU:   mem_data_out = {24'h0, sh[7:0]};
            MT_H:    mem_data_out = {{16{sh[15]}}, sh[15:0]};
            MT_HU:   mem_data_out = {16'h0, sh[15:0]};
            default: mem_data_out = raw_q;
        endcase
    end

    // Reference model: byte-addressed little-endian memory plus ownership bookkeeping.
    logic [7:0]  gmem [0:32767];
    logic        m_pend, m_boot;
    logic [14:0] m_paddr;
    logic [2:0]  m_ptype;
    logic [12:0] m_cnt;
    logic [31:0] m_rdata;

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        n_vec++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s @%0t: got %h, want %h", nm, $time, act, exp);
        end
    endtask

    function automatic logic is_misaligned(input logic [14:0] a, input logic [2:0] t);
        int sz;
        case (t)
            MT_B, MT_BU: sz = 1;
            MT_H, MT_HU: sz = 2;
            MT_W:        sz = 4;
            default:     return 1'b1;
        endcase
        return (int'(a) % sz) != 0;
    endfunction

    function automatic void gstore(input logic [14:0] a, input logic [2:0] t, input logic [31:0] d);
        int n;
        n = (t == MT_W) ? 4 : (t[0] ? 2 : 1);
        for (int i = 0; i < n; i++) gmem[int'(a) + i] = d[8*i +: 8];
    endfunction

    function automatic logic [31:0] load_val(input logic [14:0] a, input logic [2:0] t);
        logic [7:0] b0, b1, b2, b3;
        b0 = gmem[int'(a)];
        b1 = (t == MT_B || t == MT_BU) ? 8'h0 : gmem[int'(a) + 1];
        b2 = (t == MT_W) ? gmem[int'(a) + 2] : 8'h0;
        b3 = (t == MT_W) ? gmem[int'(a) + 3] : 8'h0;
        case (t)
            MT_B:    return {{24{b0[7]}}, b0};
            MT_BU:   return {24'h0, b0};
            MT_H:    return {{16{b1[7]}}, b1, b0};
            MT_HU:   return {16'h0, b1, b0};
            default: return {b3, b2, b1, b0};
        endcase
    endfunction

    always @(negedge clk) begin : cmp_p
        logic        e_stall, e_rv, e_mis, e_br, e_mw, e_mr, chk_bus;
        logic [14:0] e_addr;
        logic [2:0]  e_type;
        logic [31:0] e_din, e_rd;
        e_stall = 1'b0; e_rv = 1'b0; e_mis = 1'b0; e_br = 1'b0; e_mw = 1'b0; e_mr = 1'b0;
        e_addr = '0; e_type = MT_W; e_din = '0; e_rd = m_rdata; chk_bus = 1'b0;
        if (rst) begin
            e_rd = '0; chk_bus = 1'b1;
        end else if (m_pend) begin
            e_rv = 1'b1; e_mr = 1'b1; e_addr = m_paddr; e_type = m_ptype;
            e_rd = load_val(m_paddr, m_ptype); chk_bus = 1'b1;
        end else if (m_boot) begin
            e_br = 1'b1; e_stall = cpu_req;
            if (boot_valid) begin
                e_mw = 1'b1; e_addr = {boot_addr[14:2], 2'b00}; e_din = boot_wdata; chk_bus = 1'b1;
            end
        end else if (boot_mode) begin
            e_stall = cpu_req;
        end else if (cpu_req) begin
            if (is_misaligned(cpu_addr, cpu_type)) begin
                e_mis = 1'b1;
            end else begin
                e_mw = cpu_we; e_mr = !cpu_we; e_stall = !cpu_we;
                e_addr = cpu_addr; e_type = cpu_type; e_din = cpu_we ? cpu_wdata : 32'h0;
                chk_bus = 1'b1;
            end
        end

        chk("cpu_stall",    32'(cpu_stall),    32'(e_stall));
        chk("cpu_rvalid",   32'(cpu_rvalid),   32'(e_rv));
        chk("cpu_misalign", 32'(cpu_misalign), 32'(e_mis));
        chk("cpu_rdata",    cpu_rdata,         e_rd);
        chk("boot_ready",   32'(boot_ready),   32'(e_br));
        chk("boot_count",   32'(boot_count),   32'(m_cnt));
        chk("mem_write",    32'(mem_write),    32'(e_mw));
        chk("mem_read",     32'(mem_read),     32'(e_mr));
        if (chk_bus) begin
            chk("mem_addr", 32'(mem_addr), 32'(e_addr));
            chk("mem_type", 32'(mem_type), 32'(e_type));
        end
        if (e_mw || rst) chk("mem_data_in", mem_data_in, e_din);

        if (rst) begin
            m_pend = 1'b0; m_boot = 1'b0; m_cnt = '0; m_rdata = '0;
        end else if (m_pend) begin
            m_rdata = e_rd; m_pend = 1'b0;
            if (boot_mode) begin m_boot = 1'b1; m_cnt = '0; end
        end else if (m_boot) begin
            if (boot_valid) begin
                gstore({boot_addr[14:2], 2'b00}, MT_W, boot_wdata);
                m_cnt = m_cnt + 13'd1;
            end
            if (!boot_mode) m_boot = 1'b0;
        end else if (boot_mode) begin
            m_boot = 1'b1; m_cnt = '0;
        end else if (cpu_req && !e_mis) begin
            if (cpu_we) gstore(cpu_addr, cpu_type, cpu_wdata);
            else begin m_pend = 1'b1; m_paddr = cpu_addr; m_ptype = cpu_type; end
        end
    end

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    // Presents one CPU access and holds it until the stall drops; called just after a rising edge.
    task automatic cpu_acc(input logic we, input logic [14:0] a, input logic [2:0] t,
                           input logic [31:0] wd, output logic [31:0] rd,
                           output int stalls, output logic mis);
        int n;
        n = 0; stalls = 0; rd = '0; mis = 1'b0;
        cpu_req = 1'b1; cpu_we = we; cpu_addr = a; cpu_type = t; cpu_wdata = wd;
        forever begin
            @(negedge clk);
            if (!cpu_stall) begin
                rd = cpu_rdata; mis = cpu_misalign;
                break;
            end
            stalls++; n++;
            if (n > 50) begin
                n_vec++; n_err++;
                $display("FAIL acc_timeout @%0t: stall held %0d cycles, want release", $time, n);
                break;
            end
        end
        step();
        cpu_req = 1'b0;
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: bench did not finish, got timeout, want completion");
        $fatal(1, "watchdog");
    end

    initial begin
        logic [31:0] rd;
        int          st;
        logic        mi;
        for (int i = 0; i < 8192; i++) bmem[i] = '0;
        for (int i = 0; i < 32768; i++) gmem[i] = '0;
        raw_q = '0;
        m_pend = 1'b0; m_boot = 1'b0; m_cnt = '0; m_rdata = '0; m_paddr = '0; m_ptype = MT_W;
        rst = 1'b1; cpu_req = 1'b0; cpu_we = 1'b0; cpu_addr = '0; cpu_type = MT_W; cpu_wdata = '0;
        boot_mode = 1'b0; boot_valid = 1'b0; boot_addr = '0; boot_wdata = '0;

        @(negedge clk);
        chk("rst_mem_type", 32'(mem_type), 32'h2);
        chk("rst_count",    32'(boot_count), 32'h0);
        step();
        rst = 1'b0;

        // Store then load a word.
        cpu_acc(1'b1, 15'h0010, MT_W, 32'hDEADBEEF, rd, st, mi);
        chk("sw_no_stall", 32'(st), 32'h0);
        cpu_acc(1'b0, 15'h0010, MT_W, 32'h0, rd, st, mi);
        chk("lw_stall_cycles", 32'(st), 32'h1);
        chk("lw_data", rd, 32'hDEADBEEF);

        // Byte store and sign/zero extended loads.
        cpu_acc(1'b1, 15'h0013, MT_B, 32'h0000_0080, rd, st, mi);
        cpu_acc(1'b0, 15'h0013, MT_B, 32'h0, rd, st, mi);
        chk("lb_data", rd, 32'hFFFFFF80);
        cpu_acc(1'b0, 15'h0013, MT_BU, 32'h0, rd, st, mi);
        chk("lbu_data", rd, 32'h00000080);
        cpu_acc(1'b0, 15'h0012, MT_H, 32'h0, rd, st, mi);
        chk("lh_data", rd, 32'hFFFF80AD);
        cpu_acc(1'b0, 15'h0012, MT_HU, 32'h0, rd, st, mi);
        chk("lhu_data", rd, 32'h000080AD);
        cpu_acc(1'b1, 15'h0016, MT_H, 32'h0000_1234, rd, st, mi);
        cpu_acc(1'b0, 15'h0014, MT_W, 32'h0, rd, st, mi);
        chk("sh_lw_data", rd, 32'h12340000);

        // Misaligned and illegal accesses are dropped.
        cpu_acc(1'b0, 15'h0011, MT_H, 32'h0, rd, st, mi);
        chk("lh_mis_flag", 32'(mi), 32'h1);
        chk("lh_mis_stall", 32'(st), 32'h0);
        cpu_acc(1'b0, 15'h0012, MT_W, 32'h0, rd, st, mi);
        chk("lw_mis_flag", 32'(mi), 32'h1);
        cpu_acc(1'b0, 15'h0000, 3'b011, 32'h0, rd, st, mi);
        chk("type011_mis_flag", 32'(mi), 32'h1);
        cpu_acc(1'b1, 15'h0001, MT_W, 32'hFFFFFFFF, rd, st, mi);
        chk("sw_mis_flag", 32'(mi), 32'h1);
        cpu_acc(1'b0, 15'h0000, MT_W, 32'h0, rd, st, mi);
        chk("sw_mis_no_write", rd, 32'h0);

        // Boot session with a CPU load held off throughout.
        boot_mode = 1'b1; cpu_req = 1'b1; cpu_we = 1'b0; cpu_addr = 15'h0004; cpu_type = MT_W;
        @(negedge clk);
        chk("boot_entry_stall", 32'(cpu_stall), 32'h1);
        chk("boot_entry_ready", 32'(boot_ready), 32'h0);
        step(); boot_valid = 1'b1; boot_addr = 15'h0000; boot_wdata = 32'h11111111;
        @(negedge clk);
        chk("boot_w0_addr", 32'(mem_addr), 32'h0000);
        chk("boot_w0_ready", 32'(boot_ready), 32'h1);
        step(); boot_addr = 15'h0004; boot_wdata = 32'h22222222;
        @(negedge clk);
        chk("boot_w1_addr", 32'(mem_addr), 32'h0004);
        step(); boot_valid = 1'b0;
        @(negedge clk);
        chk("boot_gap_nowrite", 32'(mem_write), 32'h0);
        step(); boot_valid = 1'b1; boot_addr = 15'h0009; boot_wdata = 32'h33333333;
        @(negedge clk);
        chk("boot_w2_addr", 32'(mem_addr), 32'h0008);
        chk("boot_w2_stall", 32'(cpu_stall), 32'h1);
        step(); boot_valid = 1'b0;
        @(negedge clk);
        chk("boot_count3", 32'(boot_count), 32'h3);
        step(); boot_mode = 1'b0; boot_valid = 1'b1; boot_addr = 15'h000C; boot_wdata = 32'h44444444;
        @(negedge clk);
        chk("boot_last_write", 32'(mem_write), 32'h1);
        chk("boot_last_addr", 32'(mem_addr), 32'h000C);
        step(); boot_valid = 1'b0;
        cpu_acc(1'b0, 15'h0004, MT_W, 32'h0, rd, st, mi);
        chk("post_boot_lw4", rd, 32'h22222222);
        chk("boot_count4", 32'(boot_count), 32'h4);
        cpu_acc(1'b0, 15'h0008, MT_W, 32'h0, rd, st, mi);
        chk("post_boot_lw8", rd, 32'h33333333);
        cpu_acc(1'b0, 15'h000C, MT_W, 32'h0, rd, st, mi);
        chk("post_boot_lwC", rd, 32'h44444444);

        // boot_mode rising while a load is in its data cycle.
        cpu_req = 1'b1; cpu_we = 1'b0; cpu_addr = 15'h0000; cpu_type = MT_W;
        @(negedge clk);
        chk("rdboot_issue_stall", 32'(cpu_stall), 32'h1);
        step(); boot_mode = 1'b1;
        @(negedge clk);
        chk("rdboot_rvalid", 32'(cpu_rvalid), 32'h1);
        chk("rdboot_rdata", cpu_rdata, 32'h11111111);
        step(); cpu_req = 1'b0;
        @(negedge clk);
        chk("rdboot_ready", 32'(boot_ready), 32'h1);
        chk("rdboot_count_clr", 32'(boot_count), 32'h0);
        step(); boot_mode = 1'b0;
        @(negedge clk);
        step();

        // Reset during the data cycle of a load.
        cpu_req = 1'b1; cpu_we = 1'b0; cpu_addr = 15'h0010; cpu_type = MT_W;
        @(negedge clk);
        chk("rst_ld_stall", 32'(cpu_stall), 32'h1);
        step(); rst = 1'b1;
        @(negedge clk);
        chk("rst_ld_no_rvalid", 32'(cpu_rvalid), 32'h0);
        step(); rst = 1'b0; cpu_req = 1'b0;
        @(negedge clk);
        chk("rst_after_rvalid", 32'(cpu_rvalid), 32'h0);
        chk("rst_after_rdata", cpu_rdata, 32'h0);
        chk("rst_after_read", 32'(mem_read), 32'h0);
        step();
        cpu_acc(1'b0, 15'h0010, MT_W, 32'h0, rd, st, mi);
        chk("rst_recover_lw", rd, 32'h80ADBEEF);

        repeat (2) @(negedge clk);
        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
